imi_data_sched: RTL and testbench

- Sequencer for the imitator channel's navigation-data path.
- Aligns pack boundaries to sec2_pulse and counts symbols per epoch.
- Schedules ping-pong loading of the two CPU data buffers (DATA_0/DATA_1) into the data-symbol shifter.
- Tracks buffer ownership between CPU and shifter, requests refills and flags underruns.
- Sits between the channel register bank and the symbol shifter.

---
 rtl/imi_data_sched.sv | 101 ++++++++++
 tb/tb_imi_data_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imi_data_sched.sv
// Navigation-data sequencer: aligns packs to sec2_pulse and ping-pongs DATA_0/DATA_1 into the shifter.
// Optional IMI_DATA_SCHED_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
module imi_data_sched #(
  parameter int SYMB_PER_PACK  = 32,
  parameter int SYMB_IDX_WIDTH = 5,
  parameter int PACK_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      epoch_pulse,
  input  logic                      sec2_pulse,
  input  logic                      wr_buf0,
  input  logic                      wr_buf1,
  input  logic                      underrun_clr,
  output logic                      load_pulse,
  output logic                      load_sel,
  output logic                      shift_pulse,
  output logic [1:0]                buf_full,
  output logic                      irq,
  output logic                      underrun,
`ifdef IMI_DATA_SCHED_UNDERRUN_CNT_EN
  output logic [7:0]                underrun_cnt,
`endif
  output logic [SYMB_IDX_WIDTH-1:0] symb_idx,
  output logic [PACK_CNT_WIDTH-1:0] pack_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [SYMB_IDX_WIDTH-1:0] IDX_LAST = SYMB_IDX_WIDTH'(SYMB_PER_PACK - 1);
  localparam logic [SYMB_IDX_WIDTH-1:0] IDX_ONE  = SYMB_IDX_WIDTH'(1);
  localparam logic [PACK_CNT_WIDTH-1:0] PACK_ONE = PACK_CNT_WIDTH'(1);

  logic [1:0] state;
  logic       nxt;
  logic       run_ok;
  logic       wr_sel;
  logic       underrun_set;

  // Loads are combinational so the shifter captures the buffer on the strobe clock itself.
  always_comb begin
    run_ok       = enable && !rst &&
                   (state == ST_RUN || (state == ST_ARMED && sec2_pulse));
    load_pulse   = run_ok && (sec2_pulse || (epoch_pulse && symb_idx == IDX_LAST));
    load_sel     = sec2_pulse ? 1'b0 : nxt;
    shift_pulse  = run_ok && epoch_pulse && !load_pulse;
    irq          = load_pulse;
    wr_sel       = load_sel ? wr_buf1 : wr_buf0;
    underrun_set = load_pulse && !buf_full[load_sel] && !wr_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      nxt      <= 1'b0;
      symb_idx <= '0;
      pack_cnt <= '0;
      buf_full <= 2'b00;
      underrun <= 1'b0;
    end else begin
      // A CPU write in the same cycle as the load of that buffer keeps it full.
      buf_full[0] <= wr_buf0 | (buf_full[0] & ~(load_pulse & ~load_sel));
      buf_full[1] <= wr_buf1 | (buf_full[1] & ~(load_pulse & load_sel));
      underrun    <= underrun_set | (underrun & ~underrun_clr);
      if (!enable) begin
        state    <= ST_IDLE;
        nxt      <= 1'b0;
        symb_idx <= '0;
        pack_cnt <= '0;
      end else begin
        case (state)
          ST_IDLE:  state <= ST_ARMED;
          ST_ARMED: if (sec2_pulse) state <= ST_RUN;
          ST_RUN:   state <= ST_RUN;
          default:  state <= ST_IDLE;
        endcase
        if (load_pulse) begin
          nxt      <= ~load_sel;
          symb_idx <= '0;
          pack_cnt <= pack_cnt + PACK_ONE;
        end else if (shift_pulse) begin
          symb_idx <= symb_idx + IDX_ONE;
        end
      end
    end
  end

`ifdef IMI_DATA_SCHED_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || underrun_clr) begin
      underrun_cnt <= 8'd0;
    end else if (underrun_set && underrun_cnt != 8'hFF) begin
      underrun_cnt <= underrun_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imi_data_sched.sv
// Directed bench for imi_data_sched: per-cycle reference model compare plus hand-computed checkpoints.
module tb_imi_data_sched;

  localparam int SPP = 32;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        epoch_pulse;
  logic        sec2_pulse;
  logic        wr_buf0;
  logic        wr_buf1;
  logic        underrun_clr;
  logic        load_pulse;
  logic        load_sel;
  logic        shift_pulse;
  logic [1:0]  buf_full;
  logic        irq;
  logic        underrun;
  logic [7:0]  underrun_cnt;
  logic [4:0]  symb_idx;
  logic [15:0] pack_cnt;

  int total = 0;
  int bad   = 0;
  bit model_on = 0;

`ifndef IMI_DATA_SCHED_UNDERRUN_CNT_EN
  assign underrun_cnt = 8'd0;
`endif

  imi_data_sched #(.SYMB_PER_PACK(32), .SYMB_IDX_WIDTH(5), .PACK_CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .epoch_pulse(epoch_pulse), .sec2_pulse(sec2_pulse),
    .wr_buf0(wr_buf0), .wr_buf1(wr_buf1), .underrun_clr(underrun_clr),
    .load_pulse(load_pulse), .load_sel(load_sel), .shift_pulse(shift_pulse),
    .buf_full(buf_full), .irq(irq), .underrun(underrun),
`ifdef IMI_DATA_SCHED_UNDERRUN_CNT_EN
    .underrun_cnt(underrun_cnt),
`endif
    .symb_idx(symb_idx), .pack_cnt(pack_cnt)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: channel mode, position in pack, pack count, next buffer, buffer flags.
  int m_mode  = 0;  // 0 idle, 1 waiting for alignment, 2 running
  int m_pos   = 0;
  int m_packs = 0;
  int m_next  = 0;
  bit m_full[2] = '{0, 0};
  bit m_under = 0;
  int m_ucnt  = 0;
  bit e_load, e_shift, e_sel, e_new_under, active;
  bit wr[2];

  always @(negedge clk) begin
    if (model_on) begin
      wr[0]  = wr_buf0;
      wr[1]  = wr_buf1;
      active = enable && !rst && (m_mode == 2 || (m_mode == 1 && sec2_pulse));
      e_load = active && (sec2_pulse || (epoch_pulse && m_pos == SPP - 1));
      e_sel  = sec2_pulse ? 1'b0 : m_next[0];
      e_shift = active && epoch_pulse && !e_load;
      e_new_under = e_load && !m_full[e_sel] && !wr[e_sel];

      check("m_load", load_pulse, e_load);
      check("m_irq", irq, e_load);
      check("m_shift", shift_pulse, e_shift);
      if (e_load) check("m_sel", load_sel, e_sel);
      check("m_full", buf_full, {m_full[1], m_full[0]});
      check("m_under", underrun, m_under);
      check("m_idx", symb_idx, m_pos);
      check("m_packs", pack_cnt, m_packs);
`ifdef IMI_DATA_SCHED_UNDERRUN_CNT_EN
      check("m_ucnt", underrun_cnt, m_ucnt);
`endif

      if (rst) begin
        m_mode = 0; m_pos = 0; m_packs = 0; m_next = 0;
        m_full = '{0, 0}; m_under = 0; m_ucnt = 0;
      end else begin
        if (e_load) m_full[e_sel] = 0;
        if (wr[0]) m_full[0] = 1;
        if (wr[1]) m_full[1] = 1;
        if (e_new_under) m_under = 1;
        else if (underrun_clr) m_under = 0;
        if (underrun_clr) m_ucnt = 0;
        else if (e_new_under) m_ucnt = (m_ucnt < 255) ? m_ucnt + 1 : 255;
        if (!enable) begin
          m_mode = 0; m_pos = 0; m_packs = 0; m_next = 0;
        end else begin
          if (m_mode == 0) m_mode = 1;
          else if (m_mode == 1 && sec2_pulse) m_mode = 2;
          if (e_load) begin
            m_pos = 0;
            m_packs = (m_packs + 1) % 65536;
            m_next = 1 - int'(e_sel);
          end else if (e_shift) begin
            m_pos = m_pos + 1;
          end
        end
      end
    end
  end

  // Driver: inputs change 1 ns after the edge; checkpoints read 2 ns after the edge.
  task automatic cyc(input logic ep, input logic s2, input logic w0, input logic w1, input logic uc);
    @(posedge clk);
    #1;
    epoch_pulse = ep; sec2_pulse = s2; wr_buf0 = w0; wr_buf1 = w1; underrun_clr = uc;
    #1;
  endtask

  task automatic epochs(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0, 0, 0);
      check("shift_in_pack", shift_pulse, 1'b1);
      check("no_load_in_pack", load_pulse, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0;
    epoch_pulse = 0; sec2_pulse = 0; wr_buf0 = 0; wr_buf1 = 0; underrun_clr = 0;
    @(posedge clk);
    model_on = 1;
    cyc(0, 0, 0, 0, 0);
    rst = 1'b0;
    enable = 1'b1;
    cyc(0, 0, 0, 0, 0);
    check("rst_full", buf_full, 2'b00);
    check("rst_packs", pack_cnt, 16'd0);
    check("rst_idx", symb_idx, 5'd0);
    check("rst_under", underrun, 1'b0);
    check("idle_no_load", load_pulse, 1'b0);

    // First aligned load from DATA_0
    cyc(0, 0, 1, 0, 0);
    cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0);
    check("first_load", load_pulse, 1'b1);
    check("first_sel", load_sel, 1'b0);
    check("first_irq", irq, 1'b1);
    cyc(0, 0, 0, 0, 0);
    check("first_full", buf_full, 2'b10);
    check("first_packs", pack_cnt, 16'd1);

    // Full pack then boundary load of DATA_1
    epochs(31);
    cyc(1, 0, 0, 0, 0);
    check("bound_load", load_pulse, 1'b1);
    check("bound_sel", load_sel, 1'b1);
    check("bound_no_shift", shift_pulse, 1'b0);
    cyc(0, 0, 0, 0, 0);
    check("bound_full", buf_full, 2'b00);
    check("bound_packs", pack_cnt, 16'd2);
    check("bound_under", underrun, 1'b0);

    // Load from an empty DATA_0
    epochs(31);
    cyc(1, 0, 0, 0, 0);
    check("empty_sel", load_sel, 1'b0);
    cyc(0, 0, 0, 0, 0);
    check("empty_under", underrun, 1'b1);
`ifdef IMI_DATA_SCHED_UNDERRUN_CNT_EN
    check("empty_ucnt", underrun_cnt, 8'd1);
`endif
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    check("clr_under", underrun, 1'b0);

    // Forced resync mid-pack, with a clear racing a new underrun
    epochs(10);
    cyc(0, 0, 0, 0, 0);
    check("pre_resync_idx", symb_idx, 5'd10);
    cyc(0, 1, 0, 0, 1);
    check("resync_load", load_pulse, 1'b1);
    check("resync_sel", load_sel, 1'b0);
    cyc(0, 0, 0, 0, 0);
    check("resync_idx", symb_idx, 5'd0);
    check("resync_under_wins", underrun, 1'b1);
`ifdef IMI_DATA_SCHED_UNDERRUN_CNT_EN
    check("resync_ucnt_clr_wins", underrun_cnt, 8'd0);
`endif
    cyc(0, 0, 0, 0, 1);

    // Write to DATA_1 in the same cycle it is loaded
    epochs(31);
    cyc(1, 0, 0, 1, 0);
    check("wrload_sel", load_sel, 1'b1);
    cyc(0, 0, 0, 0, 0);
    check("wrload_full", buf_full, 2'b10);
    check("wrload_under", underrun, 1'b0);
    check("wrload_packs", pack_cnt, 16'd5);

    // Disable mid-pack, then re-arm
    epochs(7);
    cyc(0, 0, 0, 0, 0);
    check("pre_dis_idx", symb_idx, 5'd7);
    enable = 1'b0;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    check("dis_no_load", load_pulse, 1'b0);
    check("dis_idx", symb_idx, 5'd0);
    check("dis_packs", pack_cnt, 16'd0);
    check("dis_full_kept", buf_full, 2'b10);
    cyc(1, 0, 0, 0, 0);
    enable = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    check("armed_no_shift", shift_pulse, 1'b0);
    check("armed_no_load", load_pulse, 1'b0);
    cyc(1, 1, 0, 0, 0);
    check("rearm_load", load_pulse, 1'b1);
    check("rearm_no_shift", shift_pulse, 1'b0);
    cyc(0, 0, 0, 0, 0);
    check("rearm_packs", pack_cnt, 16'd1);
    check("rearm_under", underrun, 1'b1);

    // Reset while running
    epochs(3);
    rst = 1'b1;
    cyc(0, 1, 0, 0, 0);
    check("rst_cycle_no_load", load_pulse, 1'b0);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0);
    check("post_rst_full", buf_full, 2'b00);
    check("post_rst_under", underrun, 1'b0);
    check("post_rst_packs", pack_cnt, 16'd0);
    check("post_rst_idx", symb_idx, 5'd0);
    cyc(0, 0, 0, 0, 0);

    @(posedge clk);
    model_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
